// File: rtl/bin2bcd_seq_if.sv
// Handshake and data bundle between a producer of binary values and the
// bin2bcd_seq converter. The master drives the request, the slave answers.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 4
);
  logic [BIN_W-1:0]    bin_i;
  logic                start_i;
  logic                busy_o;
  logic                done_o;
  logic [4*DIGITS-1:0] word_o;
  logic                overflow_o;

  modport master (
    output bin_i,
    output start_i,
    input  busy_o,
    input  done_o,
    input  word_o,
    input  overflow_o
  );

  modport slave (
    input  bin_i,
    input  start_i,
    output busy_o,
    output done_o,
    output word_o,
    output overflow_o
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit
// per clock. The packed BCD result (most-significant digit in the top nibble)
// feeds a seven-segment display; values that do not fit in DIGITS decimal
// digits show as all-E with an overflow flag.
module bin2bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  bin2bcd_seq_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // Largest value representable in DIGITS decimal digits, fixed at elaboration.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [BIN_W-1:0] shift_q, shift_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [BCD_W-1:0] word_q, word_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;
  logic             busy;

  logic [BCD_W-1:0] bcdAdj;
  logic             binTooBig;

  // Input value compared against the decimal range limit.
  always_comb begin
    binTooBig = ({{(64 - BIN_W){1'b0}}, bus.bin_i} > MAX_VAL);
  end

  // Add 3 to every nibble that is 5 or more, ahead of the shift.
  always_comb begin
    bcdAdj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one SHIFT edge per input bit, then a single DONE edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start_i) state_d = SHIFT;
      SHIFT:   if (count_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy covers every non-idle cycle, including the DONE cycle.
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Datapath next values: capture on start, shift in SHIFT, publish in DONE.
  always_comb begin
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    word_d     = word_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          shift_d = bus.bin_i;
          bcd_d   = '0;
          count_d = CNT_W'(BIN_W);
          ovf_d   = binTooBig;
        end
      end
      SHIFT: begin
        bcd_d   = {bcdAdj[BCD_W-2:0], shift_q[BIN_W-1]};
        shift_d = {shift_q[BIN_W-2:0], 1'b0};
        count_d = count_q - CNT_W'(1);
      end
      DONE: begin
        word_d     = ovf_q ? {DIGITS{4'hE}} : bcd_q;
        overflow_d = ovf_q;
        done_d     = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset clears the conversion and the held result.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      shift_q    <= '0;
      bcd_q      <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      word_q     <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      word_q     <= word_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy_o     = busy;
  assign bus.done_o     = done_q;
  assign bus.word_o     = word_q;
  assign bus.overflow_o = overflow_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a cycle-level behavioural model built
// from decimal arithmetic is compared against the DUT every cycle, alongside
// directed conversions with hand-computed BCD results.
module tb_bin2bcd_seq;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 4;
  localparam int BCD_W  = 4 * DIGITS;

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) busIf ();

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk_i (clk),
    .rst_i (rstN),
    .bus   (busIf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned decLimit();
    int unsigned lim;
    lim = 1;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    return lim - 1;
  endfunction

  // Expected display word from plain decimal digit extraction.
  function automatic logic [BCD_W-1:0] refWord(input int unsigned v);
    logic [BCD_W-1:0] w;
    int unsigned rest;
    if (v > decLimit()) return {DIGITS{4'hE}};
    w    = '0;
    rest = v;
    for (int i = 0; i < DIGITS; i++) begin
      w[4*i +: 4] = 4'(rest % 10);
      rest        = rest / 10;
    end
    return w;
  endfunction

  // Behavioural model: an accepted start keeps the block busy for BIN_W+1
  // cycles, then the result appears together with a one-cycle done pulse.
  int              mLeft;
  int unsigned     mVal;
  logic            mDone;
  logic [BCD_W-1:0] mWord;
  logic            mOvf;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mLeft <= 0;
      mVal  <= 0;
      mDone <= 1'b0;
      mWord <= '0;
      mOvf  <= 1'b0;
    end else if (mLeft == 0) begin
      mDone <= 1'b0;
      if (busIf.start_i) begin
        mVal  <= busIf.bin_i;
        mLeft <= BIN_W + 1;
      end
    end else begin
      mLeft <= mLeft - 1;
      if (mLeft == 1) begin
        mDone <= 1'b1;
        mWord <= refWord(mVal);
        mOvf  <= (mVal > decLimit());
      end else begin
        mDone <= 1'b0;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model, plus busy-run length tracking.
  int busyRun     = 0;
  int lastBusyLen = 0;

  always @(posedge clk) begin
    #2;
    checkOutput("cyc_busy", 64'(busIf.busy_o), 64'(mLeft != 0));
    checkOutput("cyc_done", 64'(busIf.done_o), 64'(mDone));
    checkOutput("cyc_word", 64'(busIf.word_o), 64'(mWord));
    checkOutput("cyc_ovf", 64'(busIf.overflow_o), 64'(mOvf));
    if (!rstN) begin
      busyRun = 0;
    end else if (busIf.busy_o) begin
      busyRun++;
    end else if (busyRun != 0) begin
      lastBusyLen = busyRun;
      busyRun     = 0;
    end
  end

  task automatic applyStimulus(input logic [BIN_W-1:0] v);
    @(negedge clk);
    busIf.bin_i   = v;
    busIf.start_i = 1'b1;
    @(negedge clk);
    busIf.start_i = 1'b0;
  endtask

  task automatic waitDone(input string name, input logic [BCD_W-1:0] expWord,
                          input logic expOvf, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #3;
      cycles++;
    end while (!busIf.done_o && cycles < 60);
    if (!busIf.done_o) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got no done expected done within 60 cycles", name);
    end else begin
      checkOutput({name, "_word"}, 64'(busIf.word_o), 64'(expWord));
      checkOutput({name, "_ovf"}, 64'(busIf.overflow_o), 64'(expOvf));
    end
  endtask

  task automatic countDones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #3;
      if (busIf.done_o) cnt++;
    end
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_busy"}, 64'(busIf.busy_o), 64'd0);
    checkOutput({name, "_done"}, 64'(busIf.done_o), 64'd0);
    checkOutput({name, "_word"}, 64'(busIf.word_o), 64'd0);
    checkOutput({name, "_ovf"}, 64'(busIf.overflow_o), 64'd0);
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    int n;
    int cnt;
    busIf.bin_i   = '0;
    busIf.start_i = 1'b0;
    rstN          = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("initReset");
    rstN = 1'b1;

    applyStimulus(16'd9999);
    waitDone("w9999", 16'h9999, 1'b0, n);

    @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    checkResetOutputs("asyncReset");
    @(negedge clk);
    rstN = 1'b1;

    applyStimulus(16'd0);
    waitDone("w0", 16'h0000, 1'b0, n);

    applyStimulus(16'd1234);
    waitDone("w1234", 16'h1234, 1'b0, n);
    checkOutput("busyLen1234", 64'(lastBusyLen), 64'd17);

    applyStimulus(16'd10000);
    waitDone("w10000", 16'hEEEE, 1'b1, n);

    applyStimulus(16'd65535);
    waitDone("w65535", 16'hEEEE, 1'b1, n);

    applyStimulus(16'd42);
    repeat (3) @(negedge clk);
    busIf.bin_i   = 16'd7777;
    busIf.start_i = 1'b1;
    @(negedge clk);
    busIf.start_i = 1'b0;
    waitDone("w42", 16'h0042, 1'b0, n);
    countDones(20, cnt);
    checkOutput("noSecondDone", 64'(cnt), 64'd0);

    @(negedge clk);
    busIf.bin_i   = 16'd5;
    busIf.start_i = 1'b1;
    waitDone("b2b5", 16'h0005, 1'b0, n);
    busIf.bin_i = 16'd9876;
    waitDone("b2b9876", 16'h9876, 1'b0, n);
    busIf.start_i = 1'b0;
    checkOutput("b2bPeriod", 64'(n), 64'd18);

    applyStimulus(16'd321);
    repeat (6) @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    checkResetOutputs("midConvReset");
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    countDones(20, cnt);
    checkOutput("abortedNoDone", 64'(cnt), 64'd0);
    applyStimulus(16'd321);
    waitDone("w321", 16'h0321, 1'b0, n);

    repeat (800) begin
      @(negedge clk);
      busIf.start_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1)
        busIf.bin_i = 16'($urandom_range(0, 12000));
      else
        busIf.bin_i = 16'($urandom);
    end
    busIf.start_i = 1'b0;
    repeat (25) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
